// File: rtl/mem_req_sched.sv
// Two-source load-request scheduler with controller priority and a one-entry registered output.
// Define COHORT_REQ_SCHED_AGING_EN to build the parser aging counter (force-grant after MAX_WAIT losses).
module mem_req_sched #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    // source 0: controller requester
    input  logic        mem_controller_if_valid,
    output logic        mem_controller_if_ready,
    input  logic [2:0]  mem_controller_if_req_type,
    input  logic [7:0]  mem_controller_if_mshrid,
    input  logic [39:0] mem_controller_if_address,
    input  logic [2:0]  mem_controller_if_size,
    input  logic [7:0]  mem_controller_if_homeid,
    input  logic [7:0]  mem_controller_if_write_mask,
    input  logic [63:0] mem_controller_if_data_0,
    input  logic [63:0] mem_controller_if_data_1,
    // source 1: memory-parser requester
    input  logic        mem_if_valid,
    output logic        mem_if_ready,
    input  logic [2:0]  mem_if_req_type,
    input  logic [7:0]  mem_if_mshrid,
    input  logic [39:0] mem_if_address,
    input  logic [2:0]  mem_if_size,
    input  logic [7:0]  mem_if_homeid,
    input  logic [7:0]  mem_if_write_mask,
    input  logic [63:0] mem_if_data_0,
    input  logic [63:0] mem_if_data_1,
    // scheduled output
    output logic        load_req_valid,
    input  logic        load_req_ready,
    output logic [2:0]  load_req_req_type,
    output logic [7:0]  load_req_mshrid,
    output logic [39:0] load_req_address,
    output logic [2:0]  load_req_size,
    output logic [7:0]  load_req_homeid,
    output logic [7:0]  load_req_write_mask,
    output logic [63:0] load_req_data_0,
    output logic [63:0] load_req_data_1,
    output logic        grant_src,
    output logic        parser_starved
);
    localparam int PW = 3 + 8 + 40 + 3 + 8 + 8 + 64 + 64;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
        $error("mem_req_sched: MAX_WAIT must be in 1..255");
    end

    logic          out_valid_q, out_valid_d;
    logic          out_src_q, out_src_d;
    logic [PW-1:0] payload_q, payload_d;
    logic [PW-1:0] pay0, pay1;
    logic          slot_free, age_force, win0, win1;

    assign pay0 = {mem_controller_if_req_type, mem_controller_if_mshrid, mem_controller_if_address,
                   mem_controller_if_size, mem_controller_if_homeid, mem_controller_if_write_mask,
                   mem_controller_if_data_0, mem_controller_if_data_1};
    assign pay1 = {mem_if_req_type, mem_if_mshrid, mem_if_address, mem_if_size, mem_if_homeid,
                   mem_if_write_mask, mem_if_data_0, mem_if_data_1};

    assign slot_free = !out_valid_q | load_req_ready;
    assign win0      = mem_controller_if_valid & !age_force;
    assign win1      = mem_if_valid & (age_force | !mem_controller_if_valid);

    assign mem_controller_if_ready = slot_free & win0;
    assign mem_if_ready            = slot_free & win1;

`ifdef COHORT_REQ_SCHED_AGING_EN
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    logic [7:0] age_q, age_d;

    assign age_force      = (age_q == MAX_WAIT_C) & mem_if_valid;
    assign parser_starved = slot_free & age_force;

    // Only lost arbitrations age the parser; downstream stalls leave the count alone.
    always_comb begin
        age_d = age_q;
        if (!mem_if_valid || mem_if_ready) begin
            age_d = 8'd0;
        end else if (slot_free && win0 && age_q != MAX_WAIT_C) begin
            age_d = age_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q <= 8'd0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign age_force      = 1'b0;
    assign parser_starved = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        payload_d   = payload_q;
        if (mem_controller_if_ready) begin
            out_valid_d = 1'b1;
            out_src_d   = 1'b0;
            payload_d   = pay0;
        end else if (mem_if_ready) begin
            out_valid_d = 1'b1;
            out_src_d   = 1'b1;
            payload_d   = pay1;
        end else if (load_req_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            payload_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            payload_q   <= payload_d;
        end
    end

    assign load_req_valid = out_valid_q;
    assign grant_src      = out_src_q;
    assign {load_req_req_type, load_req_mshrid, load_req_address, load_req_size, load_req_homeid,
            load_req_write_mask, load_req_data_0, load_req_data_1} = payload_q;
endmodule

// File: tb/tb_mem_req_sched.sv
// Directed self-checking bench for mem_req_sched; expectations are hand-derived per vector.
// Aging-dependent expectations follow COHORT_REQ_SCHED_AGING_EN.
module tb_mem_req_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_valid, c_ready;
    logic [2:0]  c_req_type, c_size;
    logic [7:0]  c_mshrid, c_homeid, c_wmask;
    logic [39:0] c_address;
    logic [63:0] c_data_0, c_data_1;
    logic        p_valid, p_ready;
    logic [2:0]  p_req_type, p_size;
    logic [7:0]  p_mshrid, p_homeid, p_wmask;
    logic [39:0] p_address;
    logic [63:0] p_data_0, p_data_1;
    logic        o_valid, o_ready;
    logic [2:0]  o_req_type, o_size;
    logic [7:0]  o_mshrid, o_homeid, o_wmask;
    logic [39:0] o_address;
    logic [63:0] o_data_0, o_data_1;
    logic        grant_src, parser_starved;

    int checks = 0;
    int failures = 0;

    mem_req_sched #(.MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .mem_controller_if_valid(c_valid), .mem_controller_if_ready(c_ready),
        .mem_controller_if_req_type(c_req_type), .mem_controller_if_mshrid(c_mshrid),
        .mem_controller_if_address(c_address), .mem_controller_if_size(c_size),
        .mem_controller_if_homeid(c_homeid), .mem_controller_if_write_mask(c_wmask),
        .mem_controller_if_data_0(c_data_0), .mem_controller_if_data_1(c_data_1),
        .mem_if_valid(p_valid), .mem_if_ready(p_ready),
        .mem_if_req_type(p_req_type), .mem_if_mshrid(p_mshrid),
        .mem_if_address(p_address), .mem_if_size(p_size),
        .mem_if_homeid(p_homeid), .mem_if_write_mask(p_wmask),
        .mem_if_data_0(p_data_0), .mem_if_data_1(p_data_1),
        .load_req_valid(o_valid), .load_req_ready(o_ready),
        .load_req_req_type(o_req_type), .load_req_mshrid(o_mshrid),
        .load_req_address(o_address), .load_req_size(o_size),
        .load_req_homeid(o_homeid), .load_req_write_mask(o_wmask),
        .load_req_data_0(o_data_0), .load_req_data_1(o_data_1),
        .grant_src(grant_src), .parser_starved(parser_starved)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic v, input logic [39:0] a, input logic [7:0] id);
        c_valid = v; c_address = a; c_mshrid = id;
        c_req_type = 3'd1; c_size = 3'd3; c_homeid = 8'h11; c_wmask = 8'hFF;
        c_data_0 = 64'hC0DE_0000_0000_0000 | 64'(a); c_data_1 = 64'h1;
    endtask

    task automatic set_parser(input logic v, input logic [39:0] a, input logic [7:0] id);
        p_valid = v; p_address = a; p_mshrid = id;
        p_req_type = 3'd2; p_size = 3'd2; p_homeid = 8'h22; p_wmask = 8'h0F;
        p_data_0 = 64'hBEEF_0000_0000_0000 | 64'(a); p_data_1 = 64'h2;
    endtask

    initial begin
        int parser_grants;
        logic exp_p;
        set_ctrl(1'b0, 40'h0, 8'h0);
        set_parser(1'b0, 40'h0, 8'h0);
        o_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_grant_src", 64'(grant_src), 64'd0);
        check_eq("rst_address", 64'(o_address), 64'd0);
        check_eq("rst_starved", 64'(parser_starved), 64'd0);

        // controller-only request
        set_ctrl(1'b1, 40'h1000, 8'h05);
        #1;
        check_eq("t1_c_ready", 64'(c_ready), 64'd1);
        check_eq("t1_p_ready", 64'(p_ready), 64'd0);
        tick();
        set_ctrl(1'b0, 40'h0, 8'h0);
        check_eq("t1_valid", 64'(o_valid), 64'd1);
        check_eq("t1_address", 64'(o_address), 64'h1000);
        check_eq("t1_grant_src", 64'(grant_src), 64'd0);
        check_eq("t1_data_0", o_data_0, 64'hC0DE_0000_0000_1000);
        tick();
        check_eq("t1_drain", 64'(o_valid), 64'd0);

        // both valid every cycle, ready held high
`ifdef COHORT_REQ_SCHED_AGING_EN
        for (int i = 0; i < 8; i++) begin
            exp_p = (i % 4 == 3);
            set_ctrl(1'b1, 40'h2000 + 40'(i), 8'h10 + 8'(i));
            set_parser(1'b1, 40'h3000 + 40'(i), 8'h80 + 8'(i));
            #1;
            check_eq($sformatf("t2_p_ready_%0d", i), 64'(p_ready), 64'(exp_p));
            check_eq($sformatf("t2_starved_%0d", i), 64'(parser_starved), 64'(exp_p));
            tick();
            check_eq($sformatf("t2_grant_%0d", i), 64'(grant_src), 64'(exp_p));
            check_eq($sformatf("t2_mshrid_%0d", i), 64'(o_mshrid),
                     exp_p ? 64'(8'h80 + 8'(i)) : 64'(8'h10 + 8'(i)));
        end
`else
        parser_grants = 0;
        for (int i = 0; i < 50; i++) begin
            set_ctrl(1'b1, 40'h2000 + 40'(i), 8'h10 + 8'(i));
            set_parser(1'b1, 40'h3000 + 40'(i), 8'h80 + 8'(i));
            #1;
            if (p_ready || parser_starved) parser_grants++;
            tick();
            if (grant_src) parser_grants++;
        end
        check_eq("t2_parser_never_granted", 64'(parser_grants), 64'd0);
        check_eq("t2_last_mshrid", 64'(o_mshrid), 64'(8'h10 + 8'd49));
`endif
        set_ctrl(1'b0, 40'h0, 8'h0);
        set_parser(1'b0, 40'h0, 8'h0);
        tick();
        tick();
        check_eq("t2_idle", 64'(o_valid), 64'd0);

        // downstream stall with a request held
        o_ready = 1'b0;
        set_ctrl(1'b1, 40'h4000, 8'h40);
        tick();
        check_eq("t3_held_valid", 64'(o_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            set_ctrl(1'b1, 40'h5000 + 40'(i), 8'h50 + 8'(i));
            set_parser(1'b1, 40'h6000 + 40'(i), 8'h60 + 8'(i));
            #1;
            check_eq($sformatf("t3_c_ready_%0d", i), 64'(c_ready), 64'd0);
            check_eq($sformatf("t3_p_ready_%0d", i), 64'(p_ready), 64'd0);
            tick();
            check_eq($sformatf("t3_address_%0d", i), 64'(o_address), 64'h4000);
        end
        o_ready = 1'b1;
        set_ctrl(1'b1, 40'h7000, 8'h70);
        #1;
        // age unchanged (0) during the stall, so the controller still wins here
        check_eq("t3_release_c_ready", 64'(c_ready), 64'd1);
        check_eq("t3_release_starved", 64'(parser_starved), 64'd0);
        tick();
        check_eq("t3_next_address", 64'(o_address), 64'h7000);
        check_eq("t3_next_grant", 64'(grant_src), 64'd0);
        set_ctrl(1'b0, 40'h0, 8'h0);
        set_parser(1'b0, 40'h0, 8'h0);
        tick();
        check_eq("t3_drain", 64'(o_valid), 64'd0);

        // back-to-back parser requests
        for (int i = 0; i < 4; i++) begin
            set_parser(1'b1, 40'h8000 + 40'(i), 8'(i));
            tick();
            check_eq($sformatf("t4_valid_%0d", i), 64'(o_valid), 64'd1);
            check_eq($sformatf("t4_mshrid_%0d", i), 64'(o_mshrid), 64'(i));
            check_eq($sformatf("t4_grant_%0d", i), 64'(grant_src), 64'd1);
        end
        set_parser(1'b0, 40'h0, 8'h0);
        tick();
        check_eq("t4_drain", 64'(o_valid), 64'd0);

        // reset while a request is held and stalled
        o_ready = 1'b0;
        set_parser(1'b1, 40'h9000, 8'h99);
        tick();
        set_parser(1'b0, 40'h0, 8'h0);
        check_eq("t5_held_valid", 64'(o_valid), 64'd1);
        check_eq("t5_held_grant", 64'(grant_src), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", 64'(o_valid), 64'd0);
        check_eq("t5_rst_grant", 64'(grant_src), 64'd0);
        check_eq("t5_rst_address", 64'(o_address), 64'd0);
        check_eq("t5_rst_mshrid", 64'(o_mshrid), 64'd0);
        check_eq("t5_rst_starved", 64'(parser_starved), 64'd0);
        tick();
        reset = 1'b0;
        o_ready = 1'b1;
        tick();
        check_eq("t5_after_valid", 64'(o_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
